// File: rtl/audio_mix_pkg.sv
// Shared constants and FSM encoding for the audio mixer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package audio_mix_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int DAC_W      = 24;
    localparam int MUL_CYCLES = 5;
    localparam int GAIN_W     = 5;
    localparam int PROD_W     = SAMPLE_W + GAIN_W;

    // Counter value on the final shift-add step
    localparam logic [GAIN_W-1:0] MUL_LAST = GAIN_W'(MUL_CYCLES - 1);

    // Saturation limits for a 16-bit signed sample
    localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/audio_sat16.sv
// Adds two signed 16-bit samples in 17 bits and saturates back to 16 bits.
// Latency: purely combinational.
// Backpressure: none; the output follows the inputs.
module audio_sat16
    import audio_mix_pkg::*;
(
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    output logic [SAMPLE_W-1:0] y,
    output logic                clip
);

    logic [SAMPLE_W:0] sum;

    // Overflow shows up as the two top bits of the 17-bit sum disagreeing
    always_comb begin
        sum  = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        clip = sum[SAMPLE_W] ^ sum[SAMPLE_W-1];
        if (!clip) begin
            y = sum[SAMPLE_W-1:0];
        end else if (sum[SAMPLE_W]) begin
            y = SAT_MIN;
        end else begin
            y = SAT_MAX;
        end
    end

endmodule

// File: rtl/audio_mix.sv
// Mixes PSG and PCM stereo samples, applies master gain, drives the DAC words.
// Latency: fixed 6 cycles from accepted next_sample to done/updated outputs.
// Backpressure: none; strobes arriving while a mix is in flight are dropped and flagged as overrun.
module audio_mix
    import audio_mix_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                next_sample,
    input  logic [SAMPLE_W-1:0] psg_left,
    input  logic [SAMPLE_W-1:0] psg_right,
    input  logic [SAMPLE_W-1:0] pcm_left,
    input  logic [SAMPLE_W-1:0] pcm_right,
    input  logic [3:0]          master_vol,
    input  logic                mute,
    input  logic                clip_clear,
    output logic [DAC_W-1:0]    left_data,
    output logic [DAC_W-1:0]    right_data,
    output logic                done,
    output logic                clip_l,
    output logic                clip_r,
    output logic                overrun
);

    state_t              state;
    logic [GAIN_W-1:0]   cnt;
    logic [SAMPLE_W-1:0] x_l;
    logic [SAMPLE_W-1:0] x_r;
    logic [GAIN_W-1:0]   gain;
    logic                mute_q;
    logic [PROD_W-1:0]   acc_l;
    logic [PROD_W-1:0]   acc_r;
    logic [PROD_W-1:0]   add_l;
    logic [PROD_W-1:0]   add_r;
    logic [PROD_W-1:0]   acc_l_nxt;
    logic [PROD_W-1:0]   acc_r_nxt;
    logic [SAMPLE_W-1:0] sat_l;
    logic [SAMPLE_W-1:0] sat_r;
    logic                sat_clip_l;
    logic                sat_clip_r;
    logic                gain_bit;
    logic                accept;
    logic                late_strobe;
    logic                unused_prod_bits;

    audio_sat16 u_sat_l (
        .a    (psg_left),
        .b    (pcm_left),
        .y    (sat_l),
        .clip (sat_clip_l)
    );

    audio_sat16 u_sat_r (
        .a    (psg_right),
        .b    (pcm_right),
        .y    (sat_r),
        .clip (sat_clip_r)
    );

    assign accept      = (state == IDLE) && next_sample;
    assign late_strobe = (state != IDLE) && next_sample;

    // Product never exceeds 20 bits of magnitude and the low 4 bits are the discarded fraction
    assign unused_prod_bits = ^{acc_l_nxt[PROD_W-1], acc_l_nxt[3:0],
                                acc_r_nxt[PROD_W-1], acc_r_nxt[3:0]};

    // One shift-add step per MUL cycle: add the multiplicand shifted by cnt if gain bit cnt is set
    always_comb begin
        gain_bit  = |(gain & (GAIN_W'(1) << cnt));
        add_l     = gain_bit ? ({{GAIN_W{x_l[SAMPLE_W-1]}}, x_l} << cnt) : '0;
        add_r     = gain_bit ? ({{GAIN_W{x_r[SAMPLE_W-1]}}, x_r} << cnt) : '0;
        acc_l_nxt = acc_l + add_l;
        acc_r_nxt = acc_r + add_r;
    end

    // Mix FSM; the DAC words and done are registered on entry to LOAD so they are visible during LOAD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            x_l        <= '0;
            x_r        <= '0;
            gain       <= '0;
            mute_q     <= 1'b0;
            acc_l      <= '0;
            acc_r      <= '0;
            left_data  <= '0;
            right_data <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (next_sample) begin
                        x_l    <= sat_l;
                        x_r    <= sat_r;
                        gain   <= {1'b0, master_vol} + GAIN_W'(1);
                        mute_q <= mute;
                        acc_l  <= '0;
                        acc_r  <= '0;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    acc_l <= acc_l_nxt;
                    acc_r <= acc_r_nxt;
                    if (cnt == MUL_LAST) begin
                        cnt        <= '0;
                        state      <= LOAD;
                        done       <= 1'b1;
                        left_data  <= mute_q ? '0 : {acc_l_nxt[SAMPLE_W+3:4], 8'h00};
                        right_data <= mute_q ? '0 : {acc_r_nxt[SAMPLE_W+3:4], 8'h00};
                    end else begin
                        cnt <= cnt + GAIN_W'(1);
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky flags; a set event in the clearing cycle takes priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_l  <= 1'b0;
            clip_r  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            clip_l  <= (accept && sat_clip_l) || (clip_l && !clip_clear);
            clip_r  <= (accept && sat_clip_r) || (clip_r && !clip_clear);
            overrun <= late_strobe || (overrun && !clip_clear);
        end
    end

endmodule

// File: tb/tb_audio_mix.sv
// Self-checking bench for audio_mix with a scoreboard of expected DAC words.
// Latency: checks the fixed 6-cycle strobe-to-done latency.
// Backpressure: exercises overrun on strobes during a mix and during LOAD.
module tb_audio_mix;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        next_sample;
    logic [15:0] psg_left, psg_right, pcm_left, pcm_right;
    logic [3:0]  master_vol;
    logic        mute;
    logic        clip_clear;
    logic [23:0] left_data, right_data;
    logic        done, clip_l, clip_r, overrun;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [47:0] sb[$];
    logic [47:0] exp_word;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    audio_mix dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_sample (next_sample),
        .psg_left    (psg_left),
        .psg_right   (psg_right),
        .pcm_left    (pcm_left),
        .pcm_right   (pcm_right),
        .master_vol  (master_vol),
        .mute        (mute),
        .clip_clear  (clip_clear),
        .left_data   (left_data),
        .right_data  (right_data),
        .done        (done),
        .clip_l      (clip_l),
        .clip_r      (clip_r),
        .overrun     (overrun)
    );

    // Reference for one channel: saturating add, gain (vol+1), floor shift by 4
    function automatic logic [23:0] chan_model(input logic [15:0] a, input logic [15:0] b,
                                               input logic [3:0] vol, input logic m);
        int s;
        int p;
        logic [15:0] r;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        p = (s * (int'(vol) + 1)) >>> 4;
        r = p[15:0];
        return m ? 24'h0 : {r, 8'h00};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expected word
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got L=%h R=%h with no mix pending", left_data, right_data);
            end else begin
                exp_word = sb.pop_front();
                if ({left_data, right_data} !== exp_word)
                begin
                    bad++;
                    $display("FAIL mix_data: got L=%h R=%h want L=%h R=%h",
                             left_data, right_data, exp_word[47:24], exp_word[23:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_mix(input logic [15:0] pl, input logic [15:0] pr, input logic [15:0] ql,
                             input logic [15:0] qr, input logic [3:0] vol, input logic m,
                             output int t0);
        sb.push_back({chan_model(pl, ql, vol, m), chan_model(pr, qr, vol, m)});
        psg_left    = pl;
        psg_right   = pr;
        pcm_left    = ql;
        pcm_right   = qr;
        master_vol  = vol;
        mute        = m;
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        t0 = cyc;
    endtask

    // Waits for done, checks latency, then checks done drops; optionally strobes during LOAD
    task automatic wait_done(input int t0, input string name, input bit strobe_in_load);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: done=%b want 1 within 20 cycles", name, done);
        end else if (cyc - t0 + 1 != 6) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles want 6", name, cyc - t0 + 1);
        end
        if (strobe_in_load) next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_width: done=%b want 0", name, done);
        end
    endtask

    task automatic pulse_clear();
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({left_data, right_data} !== 48'h0) begin
            bad++;
            $display("FAIL reset_data: got L=%h R=%h want 0", left_data, right_data);
        end
        total++;
        if ({done, clip_l, clip_r, overrun} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got done/cl/cr/ov=%b want 0000", {done, clip_l, clip_r, overrun});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clip();
        int t0;
        start_mix(16'h4000, 16'h0000, 16'h4000, 16'h0000, 4'd15, 1'b0, t0);
        wait_done(t0, "clip_left", 1'b0);
        total++;
        if (left_data !== 24'h7FFF00) begin
            bad++;
            $display("FAIL clip_left_value: got %h want 7fff00", left_data);
        end
        total++;
        if ({clip_l, clip_r} !== 2'b10) begin
            bad++;
            $display("FAIL clip_left_flags: got cl/cr=%b want 10", {clip_l, clip_r});
        end
        pulse_clear();
        start_mix(16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 4'd15, 1'b0, t0);
        wait_done(t0, "clip_right", 1'b0);
        total++;
        if (right_data !== 24'h800000 || {clip_l, clip_r} !== 2'b01) begin
            bad++;
            $display("FAIL clip_right: got R=%h cl/cr=%b want 800000 01", right_data, {clip_l, clip_r});
        end
        pulse_clear();
        total++;
        if (clip_r !== 1'b0) begin
            bad++;
            $display("FAIL clip_clear: got clip_r=%b want 0", clip_r);
        end
    endtask

    task automatic test_gain();
        int t0;
        start_mix(16'h1000, 16'h0000, 16'h0000, 16'h0000, 4'd7, 1'b0, t0);
        wait_done(t0, "gain_half", 1'b0);
        total++;
        if (left_data !== 24'h080000) begin
            bad++;
            $display("FAIL gain_half: got %h want 080000", left_data);
        end
        start_mix(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, t0);
        wait_done(t0, "gain_floor", 1'b0);
        total++;
        if (left_data !== 24'hFFFF00) begin
            bad++;
            $display("FAIL gain_floor: got %h want ffff00", left_data);
        end
    endtask

    task automatic test_mute();
        int t0;
        start_mix(16'h1111, 16'h2222, 16'h0333, 16'h0444, 4'd15, 1'b1, t0);
        wait_done(t0, "mute", 1'b0);
        total++;
        if ({left_data, right_data} !== 48'h0) begin
            bad++;
            $display("FAIL mute: got L=%h R=%h want 0", left_data, right_data);
        end
    endtask

    task automatic test_overrun();
        int t0;
        int dc;
        pulse_clear();
        dc = done_cnt;
        start_mix(16'h1234, 16'h0100, 16'h0011, 16'h0200, 4'd9, 1'b0, t0);
        tick();
        tick();
        // strobe at N+3 with different inputs; the in-flight mix must be unaffected
        psg_left    = 16'h7000;
        psg_right   = 16'h9000;
        master_vol  = 4'd0;
        mute        = 1'b1;
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_mul: got %b want 1", overrun);
        end
        wait_done(t0, "overrun", 1'b0);
        repeat (8) tick();
        total++;
        if (done_cnt - dc != 1) begin
            bad++;
            $display("FAIL overrun_single_done: got %0d done pulses want 1", done_cnt - dc);
        end
        pulse_clear();
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        dc = done_cnt;
        start_mix(16'h0500, 16'hF000, 16'h0050, 16'h0123, 4'd3, 1'b0, t0);
        wait_done(t0, "load_strobe", 1'b1);
        repeat (8) tick();
        total++;
        if (overrun !== 1'b1 || done_cnt - dc != 1) begin
            bad++;
            $display("FAIL overrun_load: got ov=%b pulses=%0d want ov=1 pulses=1", overrun, done_cnt - dc);
        end
    endtask

    task automatic test_clear_vs_set();
        int t0;
        pulse_clear();
        clip_clear = 1'b1;
        start_mix(16'h7000, 16'h0000, 16'h7000, 16'h0000, 4'd5, 1'b0, t0);
        clip_clear = 1'b0;
        total++;
        if (clip_l !== 1'b1) begin
            bad++;
            $display("FAIL clear_vs_set: got clip_l=%b want 1", clip_l);
        end
        wait_done(t0, "clear_vs_set", 1'b0);
    endtask

    task automatic test_back_to_back();
        int t0;
        for (int i = 0; i < 8; i++) begin
            start_mix(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0), t0);
            wait_done(t0, "b2b", 1'b0);
        end
    endtask

    task automatic test_reset_abort();
        int t0;
        int dc;
        dc = done_cnt;
        start_mix(16'h2000, 16'h1000, 16'h0100, 16'h0200, 4'd15, 1'b0, t0);
        tick();
        tick();
        rst_n = 1'b0;
        void'(sb.pop_back());
        tick();
        rst_n = 1'b1;
        total++;
        if ({left_data, right_data} !== 48'h0 || {done, clip_l, clip_r, overrun} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_outputs: got L=%h R=%h flags=%b want all 0",
                     left_data, right_data, {done, clip_l, clip_r, overrun});
        end
        repeat (10) tick();
        total++;
        if (done_cnt != dc) begin
            bad++;
            $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - dc);
        end
        start_mix(16'h0400, 16'hFC00, 16'h0400, 16'h0000, 4'd11, 1'b0, t0);
        wait_done(t0, "after_abort", 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        next_sample = 1'b0;
        psg_left    = '0;
        psg_right   = '0;
        pcm_left    = '0;
        pcm_right   = '0;
        master_vol  = '0;
        mute        = 1'b0;
        clip_clear  = 1'b0;
        test_reset();
        test_clip();
        test_gain();
        test_mute();
        test_overrun();
        test_clear_vs_set();
        test_back_to_back();
        test_reset_abort();
        repeat (3) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
